inst_fetch_unit: RTL

- Instruction fetch stage; sits directly upstream of the instruction decoder in the multicycle core.
- Holds the PC and issues one 32-bit instruction read to instruction memory over a valid/ready request/response pair.
- Presents the fetched word plus its PC to the decoder with a valid/ready handshake.
- Waits for the next-PC from the writeback stage before fetching again. At most one transaction is outstanding.

---
 rtl/inst_fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding instruction read, decoder handshake,
// then waits for the writeback next-PC before fetching again.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fetch_fault,
    input  logic        npc_valid,
    input  logic [31:0] npc
);

    localparam logic [7:0] TMO = TIMEOUT[7:0];

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_NPC
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc_n;
    logic [31:0] inst_n;
    logic        fault_n;
    logic [7:0]  cnt;
    logic [7:0]  cnt_n;
    logic [7:0]  cnt_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inst        <= '0;
            fetch_fault <= 1'b0;
            cnt         <= '0;
        end else begin
            pc          <= pc_n;
            inst        <= inst_n;
            fetch_fault <= fault_n;
            cnt         <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst;
        fault_n = fetch_fault;
        cnt_n   = cnt;
        // saturating count; never wraps past TIMEOUT
        cnt_inc = (cnt == TMO) ? cnt : cnt + 8'd1;
        unique case (state)
            S_BOOT: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end
            end
            S_WAIT: begin
                // a response in the expiry cycle takes priority over the timeout
                if (mem_rsp_valid) begin
                    state_n = S_OUT;
                    fault_n = mem_rsp_err;
                    inst_n  = mem_rsp_err ? NOP_INST : mem_rsp_data;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TMO) begin
                        state_n = S_OUT;
                        fault_n = 1'b1;
                        inst_n  = NOP_INST;
                    end
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    state_n = S_NPC;
                end
            end
            S_NPC: begin
                if (npc_valid) begin
                    pc_n = npc;
                    if (npc[1:0] != 2'b00) begin
                        state_n = S_OUT;
                        fault_n = 1'b1;
                        inst_n  = NOP_INST;
                    end else begin
                        state_n = S_REQ;
                    end
                end
            end
            default: begin
                state_n = S_BOOT;
            end
        endcase
    end

    assign mem_req_valid = (state == S_REQ);
    assign mem_rsp_ready = (state == S_WAIT);
    assign inst_valid    = (state == S_OUT);
    assign mem_req_addr  = pc;

endmodule
